// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for an NUM_STAGES-deep in-order pipeline. Every
// pipeline register, including the PC, gets a 2-bit command each cycle:
//   PASS = 2'b00  load the value from the previous stage
//   HOLD = 2'b01  keep the current contents
//   BUBB = 2'b10  load a bubble (invalid slot)
//
// Per-stage stall requests are arbitrated against per-stage flush
// (redirect) pulses. The oldest stall wins among stalls, and the oldest
// flush wins among flushes. A flush whose stage is at or below the
// oldest stall cannot complete yet. It is captured as pending and is
// applied once the stall no longer covers it.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   stall_req       [NUM_STAGES]  stage s cannot advance (level)
//   flush_req       [NUM_STAGES]  stage f redirects the PC (pulse)
//   ctrl            [2*(NUM_STAGES+1)] command for register r at [2r+1:2r]
//                   r=0 is the PC. r=k sits between stage k-1 and stage k.
//   redirect_valid  PC loads the redirect target this cycle
//   redirect_stage  [SW] stage whose target is taken
//   flush_pending   a captured flush is waiting for the stall to clear
//   stall_cycles    [CNT_W] cycles with a stall command, saturating
//   flush_count     [CNT_W] redirects applied, saturating
//   timeout         sticky stall-watchdog flag
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1024,
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_STAGES-1:0]         stall_req,
    input  logic [NUM_STAGES-1:0]         flush_req,
    output logic [2*(NUM_STAGES+1)-1:0]   ctrl,
    output logic                          redirect_valid,
    output logic [SW-1:0]                 redirect_stage,
    output logic                          flush_pending,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_count,
    output logic                          timeout
);

    localparam logic [1:0]  CMD_PASS  = 2'b00;
    localparam logic [1:0]  CMD_HOLD  = 2'b01;
    localparam logic [1:0]  CMD_BUBB  = 2'b10;
    localparam int          NUM_REGS  = NUM_STAGES + 1;
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              flush_pending_reg;
    logic [SW-1:0]     pend_stage_reg;
    logic [CNT_W-1:0]  stall_cycles_reg;
    logic [CNT_W-1:0]  flush_count_reg;
    logic [15:0]       wd_cnt_reg;
    logic              timeout_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              stall_any;
    logic [SW-1:0]     stall_idx;
    logic              req_flush_any;
    logic [SW-1:0]     req_flush_idx;

    assign stall_any     = |stall_req;
    assign req_flush_any = |flush_req;

    // Highest set bit wins. Scanning upward lets later (older) hits overwrite.
    always_comb begin
        stall_idx = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stall_req[i]) begin
                stall_idx = SW'(i);
            end
        end
    end

    always_comb begin
        req_flush_idx = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush_req[i]) begin
                req_flush_idx = SW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Effective flush stage: the older of the captured and the new request.
    // A younger new request is absorbed. Its instructions are
    // already going to be killed by the pending, older redirect.
    // ------------------------------------------------------------------
    logic              flush_any;
    logic [SW-1:0]     flush_idx;

    assign flush_any = flush_pending_reg | req_flush_any;

    always_comb begin
        flush_idx = '0;
        if (flush_pending_reg && req_flush_any) begin
            flush_idx = (req_flush_idx > pend_stage_reg) ? req_flush_idx : pend_stage_reg;
        end else if (flush_pending_reg) begin
            flush_idx = pend_stage_reg;
        end else if (req_flush_any) begin
            flush_idx = req_flush_idx;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    //   flush_apply : flush completes this cycle (no stall, or stall younger)
    //   flush_defer : flush is covered by an equal/older stall -> capture
    //   stall_apply : stall command is driven this cycle
    // ------------------------------------------------------------------
    logic flush_apply;
    logic flush_defer;
    logic stall_apply;

    assign flush_apply = flush_any && (!stall_any || (stall_idx < flush_idx));
    assign flush_defer = flush_any && !flush_apply;
    assign stall_apply = stall_any && !flush_apply;

    // Indices widened by one bit so that register index NUM_STAGES and
    // stall_idx+1 are representable.
    logic [SW:0] stall_pos;
    logic [SW:0] stall_bubble_pos;
    logic [SW:0] flush_pos;

    assign stall_pos        = {1'b0, stall_idx};
    assign stall_bubble_pos = stall_pos + (SW+1)'(1);
    assign flush_pos        = {1'b0, flush_idx};

    // ------------------------------------------------------------------
    // Per-register command generation
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_cmd
        localparam logic [SW:0] REG_IDX = (SW+1)'(gi);
        logic [1:0] cmd;

        always_comb begin
            cmd = CMD_PASS;
            if (rst) begin
                cmd = CMD_BUBB;
            end else if (flush_apply) begin
                // The PC loads the redirect target. Everything from the
                // first pipeline register up to the flushing stage is killed.
                if (gi != 0 && REG_IDX <= flush_pos) begin
                    cmd = CMD_BUBB;
                end
            end else if (stall_apply) begin
                // Stalled stage and everything younger freeze. The register
                // just past it receives a bubble so the older part drains.
                if (REG_IDX <= stall_pos) begin
                    cmd = CMD_HOLD;
                end else if (REG_IDX == stall_bubble_pos) begin
                    cmd = CMD_BUBB;
                end
            end
        end

        assign ctrl[2*gi +: 2] = cmd;
    end

    assign redirect_valid = !rst && flush_apply;
    assign redirect_stage = (!rst && flush_apply) ? flush_idx : '0;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    logic [16:0] wd_inc;
    assign wd_inc = {1'b0, wd_cnt_reg} + 17'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending_reg <= 1'b0;
            pend_stage_reg    <= '0;
            stall_cycles_reg  <= '0;
            flush_count_reg   <= '0;
            wd_cnt_reg        <= '0;
            timeout_reg       <= 1'b0;
        end else begin
            // Pending flush capture / release
            flush_pending_reg <= flush_defer;
            if (flush_defer) begin
                pend_stage_reg <= flush_idx;
            end else if (flush_apply) begin
                pend_stage_reg <= '0;
            end

            // Saturating statistics
            if (flush_apply && (flush_count_reg != {CNT_W{1'b1}})) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
            if (stall_apply && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end

            // Watchdog: consecutive stall cycles. The flag is raised on
            // the same edge at which the run length reaches TIMEOUT.
            if (stall_apply) begin
                if (wd_cnt_reg != 16'hFFFF) begin
                    wd_cnt_reg <= wd_inc[15:0];
                end
                if (wd_inc >= TIMEOUT_W) begin
                    timeout_reg <= 1'b1;
                end
            end else begin
                wd_cnt_reg <= '0;
            end
        end
    end

    assign flush_pending = flush_pending_reg;
    assign stall_cycles  = stall_cycles_reg;
    assign flush_count   = flush_count_reg;
    assign timeout       = timeout_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios plus randomized traffic for pipe_hazard_ctrl
// (NUM_STAGES=4, narrow counters so saturation is reachable, TIMEOUT=8).
// The reference model works from the rule set directly: find the oldest
// stall and the oldest flush, decide who wins, and paint the register
// commands.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NS   = 4;
    localparam int NR   = NS + 1;
    localparam int CW   = 6;
    localparam int TO   = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [1:0] P = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;

    logic               clk;
    logic               rst;
    logic [NS-1:0]      stall_req;
    logic [NS-1:0]      flush_req;
    logic [2*NR-1:0]    ctrl;
    logic               redirect_valid;
    logic [1:0]         redirect_stage;
    logic               flush_pending;
    logic [CW-1:0]      stall_cycles;
    logic [CW-1:0]      flush_count;
    logic               timeout;

    int n_checks;
    int n_errors;

    pipe_hazard_ctrl #(
        .NUM_STAGES (NS),
        .CNT_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .ctrl           (ctrl),
        .redirect_valid (redirect_valid),
        .redirect_stage (redirect_stage),
        .flush_pending  (flush_pending),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit m_pend;
    int m_pend_stage;
    int m_stall_cycles;
    int m_flush_count;
    int m_consec;
    bit m_timeout;

    task automatic model_reset();
        m_pend         = 0;
        m_pend_stage   = 0;
        m_stall_cycles = 0;
        m_flush_count  = 0;
        m_consec       = 0;
        m_timeout      = 0;
    endtask

    // What the unit should do this cycle, given the requests.
    function automatic void model_eval(input logic [NS-1:0] st, input logic [NS-1:0] fl,
                                       output logic [2*NR-1:0] c, output bit rv, output int rs,
                                       output bit stall_cmd, output bit flush_cmd, output int f_eff);
        int s;
        int f;
        s = -1;
        f = -1;
        for (int i = 0; i < NS; i++) begin
            if (st[i]) s = i;
            if (fl[i]) f = i;
        end
        if (m_pend && m_pend_stage > f) f = m_pend_stage;
        flush_cmd = (f >= 0) && (s < f);
        stall_cmd = (s >= 0) && !flush_cmd;
        rv = flush_cmd;
        rs = flush_cmd ? f : 0;
        f_eff = f;
        c = '0;
        for (int r = 0; r < NR; r++) begin
            logic [1:0] cmd;
            cmd = P;
            if (flush_cmd) begin
                if (r >= 1 && r <= f) cmd = B;
            end else if (stall_cmd) begin
                if (r <= s) cmd = H;
                else if (r == s + 1) cmd = B;
            end
            c[2*r +: 2] = cmd;
        end
    endfunction

    // Advance the model across one clock edge with these requests applied.
    task automatic model_commit(input logic [NS-1:0] st, input logic [NS-1:0] fl);
        logic [2*NR-1:0] c;
        bit rv, sc, fc;
        int rs, fe;
        model_eval(st, fl, c, rv, rs, sc, fc, fe);
        if (fc) begin
            m_pend = 0;
            if (m_flush_count < CMAX) m_flush_count++;
        end else if (fe >= 0) begin
            m_pend       = 1;
            m_pend_stage = fe;
        end
        if (sc) begin
            if (m_stall_cycles < CMAX) m_stall_cycles++;
            if (m_consec < 65535) m_consec++;
            if (m_consec >= TO) m_timeout = 1;
        end else begin
            m_consec = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus plumbing (no checking here)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NS-1:0] st, input logic [NS-1:0] fl);
        stall_req = st;
        flush_req = fl;
        #1;
    endtask

    task automatic advance(input logic [NS-1:0] st, input logic [NS-1:0] fl);
        model_commit(st, fl);
        tick();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        stall_req = '0;
        flush_req = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive(4'($urandom), 4'($urandom));
        $display("reset: rst=1 stall=%b flush=%b ctrl=%h", stall_req, flush_req, ctrl);
        n_checks++; if (ctrl !== 10'h2AA) begin n_errors++; $display("FAIL reset_ctrl got=%h want=%h", ctrl, 10'h2AA); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rv got=%b want=0", redirect_valid); end
        n_checks++; if (redirect_stage !== 2'd0) begin n_errors++; $display("FAIL reset_rs got=%0d want=0", redirect_stage); end
        tick();
        n_checks++; if ({flush_pending, stall_cycles, flush_count, timeout} !== '0) begin
            n_errors++; $display("FAIL reset_regs got pend=%b sc=%0d fc=%0d to=%b want all 0",
                                 flush_pending, stall_cycles, flush_count, timeout);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        do_reset();
        drive(4'b0000, 4'b0000);
        $display("idle: ctrl=%h rv=%b", ctrl, redirect_valid);
        n_checks++; if (ctrl !== 10'h000) begin n_errors++; $display("FAIL idle_ctrl got=%h want=%h", ctrl, 10'h000); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL idle_rv got=%b want=0", redirect_valid); end
        advance(4'b0000, 4'b0000);
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0100, 4'b0000);
            $display("stall: cyc=%0d ctrl=%h rv=%b", c, ctrl, redirect_valid);
            n_checks++; if (ctrl !== 10'h095) begin n_errors++; $display("FAIL stall_ctrl cyc=%0d got=%h want=%h", c, ctrl, 10'h095); end
            n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL stall_rv cyc=%0d got=%b want=0", c, redirect_valid); end
            advance(4'b0100, 4'b0000);
        end
        drive(4'b0000, 4'b0000);
        n_checks++; if (stall_cycles !== CW'(3)) begin n_errors++; $display("FAIL stall_count got=%0d want=3", stall_cycles); end
        n_checks++; if (ctrl !== 10'h000) begin n_errors++; $display("FAIL stall_release got=%h want=%h", ctrl, 10'h000); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(4'b0000, 4'b0100);
        $display("flush: ctrl=%h rv=%b rs=%0d", ctrl, redirect_valid, redirect_stage);
        n_checks++; if (redirect_valid !== 1'b1) begin n_errors++; $display("FAIL flush_rv got=%b want=1", redirect_valid); end
        n_checks++; if (redirect_stage !== 2'd2) begin n_errors++; $display("FAIL flush_rs got=%0d want=2", redirect_stage); end
        n_checks++; if (ctrl !== 10'h028) begin n_errors++; $display("FAIL flush_ctrl got=%h want=%h", ctrl, 10'h028); end
        advance(4'b0000, 4'b0100);
        drive(4'b0000, 4'b0000);
        n_checks++; if (flush_count !== CW'(1)) begin n_errors++; $display("FAIL flush_count got=%0d want=1", flush_count); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL flush_once got=%b want=0", redirect_valid); end
    endtask

    task automatic test_deferred_flush();
        do_reset();
        drive(4'b1000, 4'b0100);
        $display("defer: cyc=1 ctrl=%h rv=%b pend=%b", ctrl, redirect_valid, flush_pending);
        n_checks++; if (ctrl !== 10'h255) begin n_errors++; $display("FAIL defer_ctrl1 got=%h want=%h", ctrl, 10'h255); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL defer_rv1 got=%b want=0", redirect_valid); end
        advance(4'b1000, 4'b0100);
        drive(4'b1000, 4'b0000);
        $display("defer: cyc=2 ctrl=%h rv=%b pend=%b", ctrl, redirect_valid, flush_pending);
        n_checks++; if (flush_pending !== 1'b1) begin n_errors++; $display("FAIL defer_pend2 got=%b want=1", flush_pending); end
        n_checks++; if (ctrl !== 10'h255) begin n_errors++; $display("FAIL defer_ctrl2 got=%h want=%h", ctrl, 10'h255); end
        advance(4'b1000, 4'b0000);
        drive(4'b0000, 4'b0000);
        $display("defer: cyc=3 ctrl=%h rv=%b rs=%0d", ctrl, redirect_valid, redirect_stage);
        n_checks++; if (redirect_valid !== 1'b1 || redirect_stage !== 2'd2) begin
            n_errors++; $display("FAIL defer_apply got rv=%b rs=%0d want rv=1 rs=2", redirect_valid, redirect_stage);
        end
        n_checks++; if (ctrl !== 10'h028) begin n_errors++; $display("FAIL defer_ctrl3 got=%h want=%h", ctrl, 10'h028); end
        advance(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000);
        n_checks++; if (flush_pending !== 1'b0) begin n_errors++; $display("FAIL defer_clear got=%b want=0", flush_pending); end
        n_checks++; if (stall_cycles !== CW'(2) || flush_count !== CW'(1)) begin
            n_errors++; $display("FAIL defer_stats got sc=%0d fc=%0d want sc=2 fc=1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_pending_update();
        do_reset();
        drive(4'b1000, 4'b0010);
        advance(4'b1000, 4'b0010);
        drive(4'b1000, 4'b0100);   // older flush replaces the captured one
        advance(4'b1000, 4'b0100);
        drive(4'b1000, 4'b0001);   // younger flush is absorbed
        advance(4'b1000, 4'b0001);
        drive(4'b0000, 4'b0000);
        $display("pend_update: rv=%b rs=%0d ctrl=%h", redirect_valid, redirect_stage, ctrl);
        n_checks++; if (redirect_valid !== 1'b1 || redirect_stage !== 2'd2) begin
            n_errors++; $display("FAIL pend_update got rv=%b rs=%0d want rv=1 rs=2", redirect_valid, redirect_stage);
        end
        n_checks++; if (ctrl !== 10'h028) begin n_errors++; $display("FAIL pend_update_ctrl got=%h want=%h", ctrl, 10'h028); end
        advance(4'b0000, 4'b0000);
    endtask

    task automatic test_flush_beats_young_stall();
        do_reset();
        drive(4'b0010, 4'b1000);
        $display("flush_vs_stall: ctrl=%h rv=%b rs=%0d", ctrl, redirect_valid, redirect_stage);
        n_checks++; if (ctrl !== 10'h0A8) begin n_errors++; $display("FAIL fvs_ctrl got=%h want=%h", ctrl, 10'h0A8); end
        n_checks++; if (redirect_valid !== 1'b1 || redirect_stage !== 2'd3) begin
            n_errors++; $display("FAIL fvs_redirect got rv=%b rs=%0d want rv=1 rs=3", redirect_valid, redirect_stage);
        end
        advance(4'b0010, 4'b1000);
        drive(4'b0000, 4'b0000);
        n_checks++; if (stall_cycles !== CW'(0) || flush_count !== CW'(1)) begin
            n_errors++; $display("FAIL fvs_stats got sc=%0d fc=%0d want sc=0 fc=1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 1; c <= TO; c++) begin
            drive(4'b0001, 4'b0000);
            n_checks++; if (ctrl !== 10'h009) begin n_errors++; $display("FAIL wd_ctrl cyc=%0d got=%h want=%h", c, ctrl, 10'h009); end
            advance(4'b0001, 4'b0000);
            $display("watchdog: stalled_cycles=%0d timeout=%b", c, timeout);
            n_checks++; if (timeout !== (c >= TO)) begin
                n_errors++; $display("FAIL wd_flag cyc=%0d got=%b want=%b", c, timeout, (c >= TO));
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 4'b0000);
            advance(4'b0000, 4'b0000);
        end
        n_checks++; if (timeout !== 1'b1) begin n_errors++; $display("FAIL wd_sticky got=%b want=1", timeout); end
        n_checks++; if (ctrl !== 10'h000) begin n_errors++; $display("FAIL wd_noctrl got=%h want=%h", ctrl, 10'h000); end
        do_reset();
        n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL wd_reset got=%b want=0", timeout); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < CMAX + 6; c++) begin
            drive(4'b0010, 4'b0000);
            advance(4'b0010, 4'b0000);
        end
        drive(4'b0000, 4'b0000);
        $display("saturation: stall_cycles=%0d", stall_cycles);
        n_checks++; if (stall_cycles !== CW'(CMAX)) begin n_errors++; $display("FAIL sat_stall got=%0d want=%0d", stall_cycles, CMAX); end
    endtask

    task automatic test_reset_midstate();
        do_reset();
        drive(4'b1000, 4'b0100);
        advance(4'b1000, 4'b0100);
        drive(4'b1000, 4'b0000);
        advance(4'b1000, 4'b0000);
        rst = 1'b1;
        drive(4'b1000, 4'b0000);
        tick();
        rst = 1'b0;
        model_reset();
        drive(4'b0000, 4'b0000);
        $display("reset_mid: pend=%b rv=%b sc=%0d ctrl=%h", flush_pending, redirect_valid, stall_cycles, ctrl);
        n_checks++; if (flush_pending !== 1'b0 || redirect_valid !== 1'b0) begin
            n_errors++; $display("FAIL midrst_pend got pend=%b rv=%b want 0 0", flush_pending, redirect_valid);
        end
        n_checks++; if (stall_cycles !== CW'(0) || ctrl !== 10'h000) begin
            n_errors++; $display("FAIL midrst_state got sc=%0d ctrl=%h want 0 000", stall_cycles, ctrl);
        end
    endtask

    task automatic test_random();
        logic [NS-1:0]   st, fl;
        logic [2*NR-1:0] ec;
        bit erv, esc, efc;
        int ers, efe;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            st = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            fl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            drive(st, fl);
            model_eval(st, fl, ec, erv, ers, esc, efc, efe);
            $display("rand: cyc=%0d stall=%b flush=%b ctrl=%h rv=%b rs=%0d pend=%b", c, st, fl, ctrl,
                     redirect_valid, redirect_stage, flush_pending);
            n_checks++; if (ctrl !== ec) begin n_errors++; $display("FAIL rand_ctrl cyc=%0d got=%h want=%h", c, ctrl, ec); end
            n_checks++; if (redirect_valid !== erv || (erv && redirect_stage !== 2'(ers))) begin
                n_errors++; $display("FAIL rand_redirect cyc=%0d got rv=%b rs=%0d want rv=%b rs=%0d",
                                     c, redirect_valid, redirect_stage, erv, ers);
            end
            n_checks++; if (flush_pending !== m_pend || stall_cycles !== CW'(m_stall_cycles) ||
                            flush_count !== CW'(m_flush_count) || timeout !== m_timeout) begin
                n_errors++; $display("FAIL rand_regs cyc=%0d got pend=%b sc=%0d fc=%0d to=%b want pend=%b sc=%0d fc=%0d to=%b",
                                     c, flush_pending, stall_cycles, flush_count, timeout,
                                     m_pend, m_stall_cycles, m_flush_count, m_timeout);
            end
            advance(st, fl);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        stall_req = '0;
        flush_req = '0;
        model_reset();
        tick();
        test_reset();
        test_idle();
        test_stall();
        test_flush();
        test_deferred_flush();
        test_pending_update();
        test_flush_beats_young_stall();
        test_watchdog();
        test_saturation();
        test_reset_midstate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
